// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the register file write port from the MEM and ALU stages.
// Optional macro REG_WB_FWD_EN adds youngest-match forwarding data outputs Fwd1Data/Fwd2Data.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       MemValid,
  output logic                       MemReady,
  input  logic [AW-1:0]              MemAddr,
  input  logic [DW-1:0]              MemData,
  input  logic                       AluValid,
  output logic                       AluReady,
  input  logic [AW-1:0]              AluAddr,
  input  logic [DW-1:0]              AluData,
  input  logic                       Hold,
  output logic [AW-1:0]              Awr,
  output logic [DW-1:0]              Din,
  output logic                       WrEn,
  input  logic [AW-1:0]              Ard1,
  input  logic [AW-1:0]              Ard2,
  output logic                       Pend1,
  output logic                       Pend2,
  output logic [$clog2(DEPTH):0]     Count
`ifdef REG_WB_FWD_EN
  ,
  output logic [DW-1:0]              Fwd1Data,
  output logic [DW-1:0]              Fwd2Data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          w_mem_push;
  logic          w_alu_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_alu;
  logic          w_pend1;
  logic          w_pend2;
  logic [DW-1:0] w_fwd1;
  logic [DW-1:0] w_fwd2;

  // Ready looks only at the registered count: no credit is given for a same-cycle pop.
  assign MemReady = (r_count < CW'(DEPTH));
  assign AluReady = (MemValid && MemAddr != '0) ? (r_count <= CW'(DEPTH - 2))
                                                : (r_count < CW'(DEPTH));

  assign w_mem_push = MemValid && MemReady && (MemAddr != '0);
  assign w_alu_push = AluValid && AluReady && (AluAddr != '0);
  assign w_wr_alu   = r_wr + PW'(w_mem_push);
  assign w_pop      = (r_count != '0) && !Hold;

  assign WrEn  = w_pop;
  assign Awr   = w_pop ? r_addr[r_rd] : '0;
  assign Din   = w_pop ? r_data[r_rd] : '0;
  assign Count = r_count;

  always_ff @(posedge Clk) begin
    if (w_mem_push) begin
      r_addr[r_wr] <= MemAddr;
      r_data[r_wr] <= MemData;
    end
    if (w_alu_push) begin
      r_addr[w_wr_alu] <= AluAddr;
      r_data[w_wr_alu] <= AluData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + PW'(w_mem_push) + PW'(w_alu_push);
      r_rd    <= r_rd + PW'(w_pop);
      r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    w_fwd1  = '0;
    w_fwd2  = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rd + PW'(k);
      if (CW'(k) < r_count) begin
        if (Ard1 != '0 && r_addr[idx] == Ard1) begin
          w_pend1 = 1'b1;
          w_fwd1  = r_data[idx];
        end
        if (Ard2 != '0 && r_addr[idx] == Ard2) begin
          w_pend2 = 1'b1;
          w_fwd2  = r_data[idx];
        end
      end
    end
  end

  assign Pend1 = w_pend1;
  assign Pend2 = w_pend2;

`ifdef REG_WB_FWD_EN
  assign Fwd1Data = w_fwd1;
  assign Fwd2Data = w_fwd2;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_fwd1, w_fwd2};
`endif

endmodule
